// File: rtl/heard_indication_serializer_pkg.sv
// rtl/heard_indication_serializer_pkg.sv - shared constants and types for the heard indication serializer
`define HEARD_INDICATION_SERIALIZER_RULE_COUNT 0

package heard_indication_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } ser_state_t;

    localparam int          DEF_DATA_WIDTH = 32;
    localparam int          DEF_METH_WIDTH = 192;
    localparam int          DEF_V_WIDTH    = 192;
    localparam logic [15:0] DEF_METHOD_ID  = 16'h0001;

    // Header layout: method id in the upper half, payload word count in the lower half.
    localparam int HDR_WIDTH   = 32;
    localparam int HDR_ID_LSB  = 16;
    localparam int HDR_LEN_LSB = 0;

    function automatic logic [HDR_WIDTH-1:0] make_header(input logic [15:0] id,
                                                         input logic [15:0] nwords);
        logic [HDR_WIDTH-1:0] hdr;
        hdr = '0;
        hdr[HDR_ID_LSB  +: 16] = id;
        hdr[HDR_LEN_LSB +: 16] = nwords;
        return hdr;
    endfunction

endpackage

// File: rtl/heard_indication_serializer.sv
// rtl/heard_indication_serializer.sv - serialises heard(meth, v) calls into header plus payload words
module heard_indication_serializer
    import heard_indication_serializer_pkg::*;
#(
    parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int          METH_WIDTH = DEF_METH_WIDTH,
    parameter int          V_WIDTH    = DEF_V_WIDTH,
    parameter logic [15:0] METHOD_ID  = DEF_METHOD_ID
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  heard__ENA,
    input  logic [METH_WIDTH-1:0] heard_meth,
    input  logic [V_WIDTH-1:0]    heard_v,
    output logic                  heard__RDY,
    output logic                  msg__ENA,
    output logic [DATA_WIDTH-1:0] msg_data,
    output logic                  msg_last,
    input  logic                  msg__RDY,
    output logic [15:0]           msg_count
);

    localparam int BUF_W  = METH_WIDTH + V_WIDTH;
    localparam int NWORDS = BUF_W / DATA_WIDTH;
    localparam int BEAT_W = $clog2(NWORDS + 1);
    localparam int IDX_W  = $clog2(BUF_W);

    localparam logic [BEAT_W-1:0]    LAST_BEAT   = BEAT_W'(NWORDS - 1);
    localparam logic [HDR_WIDTH-1:0] HEADER_WORD = make_header(METHOD_ID, 16'(NWORDS));

    generate
        if ((BUF_W % DATA_WIDTH) != 0) begin : g_bad_width
            $error("heard_indication_serializer: METH_WIDTH+V_WIDTH must be a multiple of DATA_WIDTH");
        end
    endgenerate

    ser_state_t         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [15:0]        count_q, count_d;
    logic [BUF_W-1:0]   buf_q, buf_d;

    logic               accept;
    logic               load;
    logic [IDX_W-1:0]   word_lsb;

    // Word presentation: header, or the buffer slice selected by the beat counter.
    always_comb begin
        msg__ENA = (state_q != IDLE);
        msg_last = (state_q == PAYLOAD) && (beat_q == LAST_BEAT);
        word_lsb = IDX_W'(beat_q) * IDX_W'(DATA_WIDTH);
        msg_data = '0;
        case (state_q)
            HEADER:  msg_data = DATA_WIDTH'(HEADER_WORD);
            PAYLOAD: msg_data = buf_q[word_lsb +: DATA_WIDTH];
            default: msg_data = '0;
        endcase
        // Ready is combinational from msg__RDY so a new call can land on the last-word accept.
        heard__RDY = (state_q == IDLE) | (msg_last & msg__RDY);
        accept     = msg__ENA & msg__RDY;
        load       = heard__ENA & heard__RDY;
        msg_count  = count_q;
    end

    // Next-state: message sequencing, beat counting, completion count and buffer load.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        count_d = count_q;
        buf_d   = load ? {heard_v, heard_meth} : buf_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    state_d = PAYLOAD;
                    beat_d  = '0;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        count_d = count_q + 16'd1;
                        beat_d  = '0;
                        state_d = load ? HEADER : IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any message in flight.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            count_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_heard_indication_serializer.sv
// tb/tb_heard_indication_serializer.sv - scoreboard bench for heard_indication_serializer
module tb_heard_indication_serializer;

    logic         CLK;
    logic         nRST;
    logic         heard__ENA;
    logic [191:0] heard_meth;
    logic [191:0] heard_v;
    logic         heard__RDY;
    logic         msg__ENA;
    logic [31:0]  msg_data;
    logic         msg_last;
    logic         msg__RDY;
    logic [15:0]  msg_count;

    heard_indication_serializer dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .heard__ENA (heard__ENA),
        .heard_meth (heard_meth),
        .heard_v    (heard_v),
        .heard__RDY (heard__RDY),
        .msg__ENA   (msg__ENA),
        .msg_data   (msg_data),
        .msg_last   (msg_last),
        .msg__RDY   (msg__RDY),
        .msg_count  (msg_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   accepted;
    logic mon_en;
    int   rdy_mode;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Checks every accepted word against the scoreboard and every stalled word for stability.
    task automatic monitor_loop;
        logic        stall_prev;
        logic [31:0] stall_data;
        logic        stall_last;
        exp_t        e;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge CLK);
            if (!mon_en || nRST !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    vectors++;
                    if (msg__ENA !== 1'b1 || msg_data !== stall_data || msg_last !== stall_last) begin
                        miscompares++;
                        $display("FAIL stall_hold: ena=%b data=%h last=%b, required ena=1 data=%h last=%b",
                                 msg__ENA, msg_data, msg_last, stall_data, stall_last);
                    end
                end
                if (msg__ENA === 1'b1 && msg__RDY === 1'b1) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL word_unexpected: data=%h last=%b, required no word", msg_data, msg_last);
                    end else begin
                        e = sb.pop_front();
                        if (msg_data !== e.data || msg_last !== e.last) begin
                            miscompares++;
                            $display("FAIL word: data=%h last=%b, required data=%h last=%b",
                                     msg_data, msg_last, e.data, e.last);
                        end
                    end
                    accepted++;
                end
                stall_prev = (msg__ENA === 1'b1) && (msg__RDY !== 1'b1);
                stall_data = msg_data;
                stall_last = msg_last;
            end
        end
    endtask

    // Sink ready: always high, or the repeating 1,0,0,1 pattern.
    task automatic rdy_loop;
        int ph;
        ph = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_mode == 0) begin
                msg__RDY = 1'b1;
            end else begin
                msg__RDY = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
        end
    endtask

    task automatic wait_rdy(output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge CLK);
        while (heard__RDY !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (heard__RDY !== 1'b1) begin
            ok = 1'b0;
            vectors++;
            miscompares++;
            $display("FAIL rdy_timeout: heard__RDY=%b, required 1 within 300 cycles", heard__RDY);
        end
    endtask

    // Drives one heard call now (caller has seen heard__RDY) and queues its 13 expected words.
    task automatic load_msg(input logic [31:0] mb, input logic [31:0] vb);
        heard__ENA = 1'b1;
        for (int i = 0; i < 6; i++) begin
            heard_meth[i*32 +: 32] = mb + 32'(i);
            heard_v[i*32 +: 32]    = vb + 32'(i);
        end
        sb.push_back('{data: 32'h0001_000C, last: 1'b0});
        for (int i = 0; i < 6; i++) sb.push_back('{data: mb + 32'(i), last: 1'b0});
        for (int i = 0; i < 6; i++) sb.push_back('{data: vb + 32'(i), last: (i == 5)});
        @(posedge CLK);
        #1;
        heard__ENA = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] mb, input logic [31:0] vb);
        logic ok;
        wait_rdy(ok);
        if (ok) load_msg(mb, vb);
    endtask

    task automatic wait_drain_check(input logic [15:0] exp_count);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge CLK);
        vectors++;
        if (msg__ENA !== 1'b0 || msg_count !== exp_count) begin
            miscompares++;
            $display("FAIL drain_state: ena=%b count=%h, required ena=0 count=%h", msg__ENA, msg_count, exp_count);
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (msg__ENA !== 1'b0 || heard__RDY !== 1'b1 || msg_count !== 16'h0 ||
            msg_last !== 1'b0 || msg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: ena=%b rdy=%b count=%h last=%b data=%h, required 0 1 0000 0 00000000",
                     msg__ENA, heard__RDY, msg_count, msg_last, msg_data);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single;
        logic ok;
        rdy_mode = 0;
        wait_rdy(ok);
        if (ok) begin
            load_msg(32'hA000_0000, 32'hB000_0000);
            @(negedge CLK);
            vectors++;
            if (msg__ENA !== 1'b1 || msg_data !== 32'h0001_000C) begin
                miscompares++;
                $display("FAIL header_latency: ena=%b data=%h, required ena=1 data=0001000c", msg__ENA, msg_data);
            end
        end
        wait_drain_check(16'd1);
    endtask

    task automatic test_backpressure;
        rdy_mode = 1;
        send_msg(32'hA000_0000, 32'hB000_0000);
        wait_drain_check(16'd2);
        rdy_mode = 0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        logic ok;
        rdy_mode = 0;
        send_msg(32'h1000_0000, 32'h2000_0000);
        wait_rdy(ok);
        if (ok) begin
            vectors++;
            if (msg_last !== 1'b1 || msg_data !== 32'h2000_0005 || msg_count !== 16'd2) begin
                miscompares++;
                $display("FAIL b2b_last: last=%b data=%h count=%h, required 1 20000005 0002",
                         msg_last, msg_data, msg_count);
            end
            load_msg(32'h3000_0000, 32'h4000_0000);
            @(negedge CLK);
            vectors++;
            if (msg__ENA !== 1'b1 || msg_data !== 32'h0001_000C || msg_count !== 16'd3) begin
                miscompares++;
                $display("FAIL b2b_header: ena=%b data=%h count=%h, required 1 0001000c 0003",
                         msg__ENA, msg_data, msg_count);
            end
        end
        wait_drain_check(16'd4);
    endtask

    task automatic test_reset_mid;
        int base;
        int n;
        rdy_mode = 0;
        base = accepted;
        send_msg(32'h5000_0000, 32'h6000_0000);
        n = 0;
        while (accepted < base + 6 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (accepted < base + 6) begin
            vectors++;
            miscompares++;
            $display("FAIL midreset_timeout: accepted=%0d, required %0d", accepted - base, 6);
        end
        mon_en = 1'b0;
        nRST   = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        sb.delete();
        @(negedge CLK);
        vectors++;
        if (msg__ENA !== 1'b0 || msg_count !== 16'd0 || heard__RDY !== 1'b1 || msg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset: ena=%b count=%h rdy=%b data=%h, required 0 0000 1 00000000",
                     msg__ENA, msg_count, heard__RDY, msg_data);
        end
        mon_en = 1'b1;
        send_msg(32'h7000_0000, 32'h8000_0000);
        wait_drain_check(16'd1);
    endtask

    task automatic test_wrap;
        @(negedge CLK);
        force dut.count_q = 16'hFFFF;
        @(posedge CLK);
        #1;
        release dut.count_q;
        @(negedge CLK);
        vectors++;
        if (msg_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: count=%h, required ffff", msg_count);
        end
        send_msg(32'hC000_0000, 32'hD000_0000);
        wait_drain_check(16'h0000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        accepted    = 0;
        mon_en      = 1'b0;
        rdy_mode    = 0;
        nRST        = 1'b0;
        heard__ENA  = 1'b0;
        heard_meth  = '0;
        heard_v     = '0;
        msg__RDY    = 1'b1;
        fork
            monitor_loop();
            rdy_loop();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: %0d words outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
